// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the handshaked FP operation sequencer.
//   - opcode encodings and opcode width
//   - sequencer state encoding
//   - op_latency(): unit latency for an opcode
//   - binary32 arithmetic/compare helpers used by the result select.
//     These treat subnormal inputs as zero and truncate instead of rounding.
package fpu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd3;
    localparam logic [OP_W-1:0] OP_SQRT = 5'd4;
    localparam logic [OP_W-1:0] OP_MIN  = 5'd5;
    localparam logic [OP_W-1:0] OP_MAX  = 5'd6;
    localparam logic [OP_W-1:0] OP_EQ   = 5'd7;
    localparam logic [OP_W-1:0] OP_LT   = 5'd8;
    localparam logic [OP_W-1:0] OP_LE   = 5'd9;
    localparam logic [OP_W-1:0] OP_CONV = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Unit latency in cycles; every single-cycle or illegal opcode costs 1.
    function automatic int op_latency(input logic [OP_W-1:0] op,
                                      input int div_lat, input int sqrt_lat);
        int lat;
        case (op)
            OP_DIV:  lat = div_lat;
            OP_SQRT: lat = sqrt_lat;
            default: lat = 32'sd1;
        endcase
        return lat;
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    endfunction

    // Add with the larger magnitude operand as reference; subtract is add with b negated.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  ex, ey, sh;
        logic [24:0] mx, my, ms;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        ex = x[30:23];
        ey = y[30:23];
        mx = {1'b0, (ex != 8'd0), x[22:0]};
        my = {1'b0, (ey != 8'd0), y[22:0]};
        sh = ex - ey;
        my = (sh > 8'd24) ? 25'd0 : (my >> sh);
        ms = (x[31] == y[31]) ? (mx + my) : (mx - my);
        if (ms == 25'd0) return 32'd0;
        if (ms[24]) begin
            ms = ms >> 1;
            ex = ex + 8'd1;
        end
        for (int i = 0; i < 24; i++) begin
            if (!ms[23] && ex != 8'd0) begin
                ms = ms << 1;
                ex = ex - 8'd1;
            end
        end
        return {x[31], ex, ms[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] f;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin f = p[46:24]; e = e + 10'd1; end
        else       begin f = p[45:23]; end
        // e[9] set means the biased exponent went negative (wrapped).
        if (e[9] || e == 10'd0) return {s, 31'd0};
        if (e >= 10'd255)       return {s, 8'hFF, 23'd0};
        return {s, e[7:0], f};
    endfunction

    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] q;
        logic [9:0]  e;
        logic [22:0] f;
        s = a[31] ^ b[31];
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0) return {s, 31'd0};
        // Mantissa ratio scaled by 2^24, lands in [2^23, 2^25).
        q = {1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd126;
        if (q[24]) begin f = q[23:1]; e = e + 10'd1; end
        else       begin f = q[22:0]; end
        if (e[9] || e == 10'd0) return {s, 31'd0};
        if (e >= 10'd255)       return {s, 8'hFF, 23'd0};
        return {s, e[7:0], f};
    endfunction

    function automatic logic [31:0] fp_sqrt(input logic [31:0] a);
        logic [23:0] m, r, t;
        logic [47:0] rad;
        logic [7:0]  e;
        if (a[30:23] == 8'd0) return {a[31], 31'd0};
        if (a[31])            return 32'h7FC0_0000;
        m = {1'b1, a[22:0]};
        // Odd biased exponent means an even unbiased one: no extra mantissa doubling.
        rad = a[23] ? {1'b0, m, 23'd0} : {m, 24'd0};
        e = 8'(({1'b0, a[30:23]} + (a[23] ? 9'd127 : 9'd126)) >> 1);
        r = 24'd0;
        for (int i = 23; i >= 0; i--) begin
            t = r | (24'd1 << i);
            if (({24'd0, t} * {24'd0, t}) <= rad) r = t;
        end
        return {1'b0, e, r[22:0]};
    endfunction

    function automatic logic fp_eq(input logic [31:0] a, input logic [31:0] b);
        if (fp_is_nan(a) || fp_is_nan(b)) return 1'b0;
        return (a == b) || (a[30:0] == 31'd0 && b[30:0] == 31'd0);
    endfunction

    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        if (fp_is_nan(a) || fp_is_nan(b))            return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0)    return 1'b0;
        if (a[31] != b[31])                          return a[31];
        return a[31] ? (a[30:0] > b[30:0]) : (a[30:0] < b[30:0]);
    endfunction

endpackage

// File: rtl/fpu_result_sel.sv
// fpu_result_sel: combinational opcode-to-unit-output select.
//   op_i       opcode (latched copy)
//   a_i, b_i   operands (latched copies)
//   conv_i     pre-converted value returned by CONV
//   result_o   selected unit output; 0 for an illegal opcode
//   illegal_o  opcode is not a defined encoding
// The unit helpers implement binary32, so WIDTH is expected to be 32.
module fpu_result_sel
    import fpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] conv_i,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);

    logic lt_s;
    logic eq_s;

    assign lt_s = fp_lt(a_i, b_i);
    assign eq_s = fp_eq(a_i, b_i);

    // Route the unit output chosen by the opcode; compares give 0/1 in the LSB.
    always_comb begin
        result_o  = {WIDTH{1'b0}};
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:  result_o = fp_add(a_i, b_i);
            OP_SUB:  result_o = fp_add(a_i, {~b_i[WIDTH-1], b_i[WIDTH-2:0]});
            OP_MUL:  result_o = fp_mul(a_i, b_i);
            OP_DIV:  result_o = fp_div(a_i, b_i);
            OP_SQRT: result_o = fp_sqrt(a_i);
            OP_MIN:  result_o = lt_s ? a_i : b_i;
            OP_MAX:  result_o = lt_s ? b_i : a_i;
            OP_EQ:   result_o = {{(WIDTH-1){1'b0}}, eq_s};
            OP_LT:   result_o = {{(WIDTH-1){1'b0}}, lt_s};
            OP_LE:   result_o = {{(WIDTH-1){1'b0}}, (lt_s | eq_s)};
            OP_CONV: result_o = conv_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: accepts one FP op per valid/ready transaction, runs it
// through the FP units and presents a registered result on valid/ready.
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake
//   in_op, in_a, in_b, in_conv opcode and operands, in_tag opaque tag
//   flush                      synchronous abort of any in-flight op
//   out_valid/out_ready        result handshake
//   out_result, out_tag        result and the tag of the op that produced it
//   out_illegal                opcode was not a defined encoding
//   busy                       sequencer is not IDLE
module fpu_op_sequencer #(
    parameter int WIDTH    = 32,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 5,
    parameter int DIV_LAT  = 16,
    parameter int SQRT_LAT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_conv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);
    import fpu_pkg::*;

    localparam int MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, conv_q, conv_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_illegal_q, out_illegal_d;

    logic             accept_s;
    logic [WIDTH-1:0] sel_result_s;
    logic             sel_illegal_s;

    // Units see only the latched request, so input changes after accept are ignored.
    fpu_result_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .op_i      (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .conv_i    (conv_q),
        .result_o  (sel_result_s),
        .illegal_o (sel_illegal_s)
    );

    // A waiting result may be consumed and replaced on the same edge.
    assign in_ready    = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept_s    = in_valid & in_ready;
    assign busy        = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

    // Next-state, request latch, counter and output capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        conv_d        = conv_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;

        case (state_q)
            IDLE: begin
                if (accept_s) state_d = EXEC;
                else          state_d = IDLE;
            end
            EXEC: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_result_d  = sel_result_s;
                    out_tag_d     = tag_q;
                    out_illegal_d = sel_illegal_s;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept_s ? EXEC : IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // The counter covers the launch cycle from the operand registers plus
        // L unit cycles, so the result registers on edge accept+L+1.
        if (accept_s) begin
            op_d   = in_op;
            a_d    = in_a;
            b_d    = in_b;
            conv_d = in_conv;
            tag_d  = in_tag;
            cnt_d  = CNT_W'(op_latency(in_op, DIV_LAT, SQRT_LAT));
        end

        // Flush wins over everything; in_ready is already low so nothing is accepted.
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
        end
    end

    // State, request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            op_q          <= {OP_W{1'b0}};
            a_q           <= {WIDTH{1'b0}};
            b_q           <= {WIDTH{1'b0}};
            conv_q        <= {WIDTH{1'b0}};
            tag_q         <= {TAG_W{1'b0}};
            out_valid_q   <= 1'b0;
            out_result_q  <= {WIDTH{1'b0}};
            out_tag_q     <= {TAG_W{1'b0}};
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            conv_q        <= conv_d;
            tag_q         <= tag_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: directed vectors push expected
// results into a scoreboard queue; a monitor pops and compares on each
// output handshake.
module tb_fpu_op_sequencer;

    localparam int WIDTH    = 32;
    localparam int TAG_W    = 4;
    localparam int OP_W     = 5;
    localparam int DIV_LAT  = 16;
    localparam int SQRT_LAT = 16;

    localparam logic [4:0] T_ADD = 5'd0, T_SUB = 5'd1, T_MUL = 5'd2, T_DIV = 5'd3,
                           T_SQRT = 5'd4, T_MIN = 5'd5, T_MAX = 5'd6, T_EQ = 5'd7,
                           T_LT = 5'd8, T_LE = 5'd9, T_CONV = 5'd10;

    localparam logic [31:0] F_M1 = 32'hBF80_0000, F_1 = 32'h3F80_0000, F_2 = 32'h4000_0000,
                            F_3 = 32'h4040_0000, F_4 = 32'h4080_0000, F_5 = 32'h40A0_0000,
                            F_6 = 32'h40C0_0000, F_16 = 32'h4180_0000;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_illegal, busy;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_a, in_b, in_conv, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    fpu_op_sequencer #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .OP_W(OP_W), .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_conv(in_conv), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got result %h tag %0d, expected no result",
                         out_result, out_tag);
            end else begin
                mon_e = sb_q.pop_front();
                if ({out_result, out_tag, out_illegal} !== mon_e) begin
                    n_bad++;
                    $display("FAIL result: got %h tag %0d ill %0b, expected %h tag %0d ill %0b",
                             out_result, out_tag, out_illegal, mon_e.res, mon_e.tag, mon_e.ill);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request until accepted; optionally record its expected result.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] conv, input logic [3:0] tag, input logic push,
                        input logic [31:0] eres, input logic eill);
        int   guard = 0;
        exp_t e;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_conv = conv; in_tag = tag;
        while (!in_ready && guard < 100) begin
            tick(1);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
        end else if (push) begin
            e.res = eres; e.tag = tag; e.ill = eill;
            sb_q.push_back(e);
        end
        tick(1);
        // Scramble inputs: the DUT must use only its latched copy.
        in_valid = 1'b0; in_op = 5'd31; in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D;
        in_conv = 32'hFFFF_FFFF; in_tag = 4'hF;
    endtask

    // Count edges after the accept edge until out_valid rises.
    task automatic wait_valid(input string name, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick(1);
            n++;
        end
        check(name, n, exp_lat);
    endtask

    logic [4:0]  v_op  [5] = '{T_MIN, T_MAX, T_EQ, T_LE, T_CONV};
    logic [31:0] v_a   [5] = '{F_M1, F_1, F_2, F_2, 32'd0};
    logic [31:0] v_b   [5] = '{F_2, F_2, F_2, F_1, 32'd0};
    logic [31:0] v_exp [5] = '{F_M1, F_2, 32'h1, 32'h0, 32'h1234_5678};

    initial begin
        int seen;
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_op = 5'd0; in_a = 32'd0; in_b = 32'd0; in_conv = 32'd0; in_tag = 4'd0;
        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", out_tag, 4'd0);
        check("rst_out_illegal", out_illegal, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // ADD 1.0 + 2.0
        send(T_ADD, F_1, F_2, 32'd0, 4'd3, 1'b1, F_3, 1'b0);
        check("add_in_ready_low", in_ready, 1'b0);
        wait_valid("add_latency", 2);
        check("add_in_ready_back", in_ready, 1'b1);
        tick(1);

        // DIV 6.0 / 2.0
        send(T_DIV, F_6, F_2, 32'd0, 4'd5, 1'b1, F_3, 1'b0);
        check("div_busy", busy, 1'b1);
        wait_valid("div_latency", DIV_LAT + 1);
        tick(1);

        // Backpressure on MUL 2.0 * 3.0, then same-edge dequeue + SUB accept
        out_ready = 1'b0;
        send(T_MUL, F_2, F_3, 32'd0, 4'd1, 1'b1, F_6, 1'b0);
        wait_valid("mul_latency", 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_result", out_result, F_6);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            tick(1);
        end
        out_ready = 1'b1;
        #1;
        check("same_edge_in_ready", in_ready, 1'b1);
        send(T_SUB, F_5, F_1, 32'd0, 4'd2, 1'b1, F_4, 1'b0);
        check("b2b_valid_low", out_valid, 1'b0);
        check("b2b_busy", busy, 1'b1);
        wait_valid("sub_latency", 2);
        tick(1);

        // Illegal opcode
        send(5'd20, F_1, F_2, F_3, 4'd7, 1'b1, 32'd0, 1'b1);
        wait_valid("illegal_latency", 2);
        tick(1);

        // Flush a SQRT in flight; a request offered during flush must be refused
        send(T_SQRT, F_16, 32'd0, 32'd0, 4'd6, 1'b0, 32'd0, 1'b0);
        tick(3);
        flush = 1'b1;
        in_valid = 1'b1; in_op = T_ADD; in_a = F_1; in_b = F_1; in_tag = 4'd14;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick(1);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_idle", busy, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        check("flush_valid", out_valid, 1'b0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            tick(1);
        end
        check("flush_no_result", seen, 0);
        send(T_LT, F_1, F_2, 32'd0, 4'd4, 1'b1, 32'h1, 1'b0);
        wait_valid("lt_latency", 2);
        tick(1);

        // Remaining single-cycle ops
        for (int i = 0; i < 5; i++) begin
            send(v_op[i], v_a[i], v_b[i], 32'h1234_5678, 4'(8 + i), 1'b1, v_exp[i], 1'b0);
            wait_valid("vec_latency", 2);
            tick(1);
        end

        // Async reset in the middle of a DIV, away from the clock edge
        send(T_DIV, F_6, F_2, 32'd0, 4'd9, 1'b0, 32'd0, 1'b0);
        tick(6);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_tag", out_tag, 4'd0);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            tick(1);
        end
        check("arst_no_stale", seen, 0);
        send(T_ADD, F_1, F_1, 32'd0, 4'd13, 1'b1, F_2, 1'b0);
        wait_valid("post_rst_add_latency", 2);
        tick(1);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
